fetch_req_ctrl: RTL and testbench
=================================

// Module: fetch_req_ctrl
// PURPOSE
//  Sequences instruction-fetch requests from prefetch into the ICache.
//  Holds one fetch-group PC until the ICache accepts it (addr_ok).
//  Tracks accepted-but-unanswered requests and drops responses that belong to a flushed stream.
//  Only responses for the live stream reach the fetch queue, as resp_valid.
// PARAMETERS
//  MAX_OUTSTANDING  2                               max addr-accepted requests awaiting data_ok (>=1)
//  CNT_W            $clog2(MAX_OUTSTANDING+1)       width of inflight and cancel counters
// PORTS
//  clk              in   1      clock
//  resetn           in   1      reset, asynchronous, active-low
//  flush            in   1      pipeline flush; kills current stream
//  req_valid        in   1      prefetch offers a fetch-group PC
//  req_pc           in   32     fetch-group PC (8-byte aligned)
//  req_ready        out  1      PC accepted when req_valid && req_ready
//  icache_req       out  1      request to ICache
//  icache_addr      out  32     request address (registered, stable while icache_req)
//  icache_addr_ok   in   1      ICache accepted address this cycle
//  icache_data_ok   in   1      ICache returns data this cycle (no backpressure)
//  icache_rdata1    in   32     instruction at addr
//  icache_rdata2    in   32     instruction at addr+4
//  resp_valid       out  1      live response this cycle
//  resp_rdata1      out  32     = icache_rdata1
//  resp_rdata2      out  32     = icache_rdata2
//  inflight         out  CNT_W  outstanding accepted requests, live + cancelled
//  protocol_err     out  1      sticky: data_ok seen with inflight==0
// BEHAVIOUR
//  Reset values (async, resetn low):
//   - state=IDLE, inflight=0, cancel_cnt=0, icache_addr=0, protocol_err=0.
//   - Therefore icache_req=0, req_ready=0 until reset is released, resp_valid=0.
//  Handshakes: addr_hs = icache_req && icache_addr_ok; dat = icache_data_ok.
//  FSM:
//   - IDLE: no held request.
//     - req_valid && req_ready -> REQ; latch icache_addr<=req_pc.
//   - REQ: held live request.
//     - flush && !addr_hs -> REQ_KILL.
//     - addr_hs: if a new PC is accepted the same cycle -> REQ, else -> IDLE.
//   - REQ_KILL: held request of a flushed stream; cannot be withdrawn.
//     - addr_hs -> IDLE; this request counts as cancelled.
//  icache_req = (state!=IDLE) && (inflight < MAX_OUTSTANDING). It is registered-state only; no combinational path from req_valid.
//  req_ready = !flush && (state==IDLE || (state==REQ && addr_hs)).
//   - Latency: PC accepted in cycle N -> icache_req in N+1.
//   - Back-to-back throughput: 1 request per cycle.
//  Counters:
//   - inflight_nxt = inflight + addr_hs - (dat && inflight!=0). Never exceeds MAX_OUTSTANDING.
//   - Drop condition: a dat is dropped iff cancel_cnt!=0 || flush. It decrements cancel_cnt when cancel_cnt!=0.
//   - flush cycle: cancel_cnt <= inflight_nxt, so every request accepted up to and including this cycle is cancelled.
//   - REQ_KILL addr_hs: cancel_cnt <= cancel_cnt + 1 (minus 1 if a dropped dat occurs in the same cycle).
//   - Invariant: cancel_cnt <= inflight at all times.
//  resp_valid = dat && cancel_cnt==0 && !flush; resp_rdata* pass combinationally.
//  Simultaneous events:
//   - addr_hs and dat in the same cycle: inflight unchanged.
//   - flush with addr_hs in REQ: the accepted request is cancelled and the FSM goes to IDLE; flush blocks a new PC that cycle.
//   - flush in REQ_KILL: stays in REQ_KILL; cancel_cnt recomputed per the flush rule, with the held request still pending.
//  Boundaries:
//   - dat with inflight==0: ignored, resp_valid=0, protocol_err<=1.
//   - inflight==MAX: icache_req=0 until a dat arrives.
//   - Counters never wrap.
//   - Reset mid-operation: all state cleared immediately; ICache-side recovery is the system's responsibility.
// TESTING
//  1. Reset, req_valid=1 pc=0xBFC00000, addr_ok=1 every cycle, data_ok 2 cycles later -> icache_req at cycle 1; resp_valid one cycle per request; inflight<=2.
//  2. MAX=2, addr_ok=1, data_ok withheld -> after 2 accepts icache_req=0, req_ready=0; first data_ok -> icache_req reasserts next cycle.
//  3. 2 requests in flight, flush -> cancel_cnt=2; next 2 data_ok give resp_valid=0; third data_ok (new pc 0x80000180) gives resp_valid=1.
//  4. REQ with addr_ok=0, flush -> REQ_KILL, icache_addr unchanged; addr_ok 3 cycles later -> IDLE, cancel_cnt+1; its data_ok dropped.
//  5. flush same cycle as addr_hs and data_ok with inflight=1 -> inflight stays 1, cancel_cnt=1, resp_valid=0, req_ready=0.
//  6. data_ok with inflight=0 -> protocol_err=1 and stays 1; resetn low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_req_ctrl.sv
// Issues fetch-group PCs to the ICache, one held request at a time, and drops responses of flushed streams.
// Latency: PC accepted in cycle N is presented to the ICache in N+1; responses pass through combinationally.
// Backpressure: req_ready drops while a request is held and not yet accepted, or when MAX_OUTSTANDING is reached.
module fetch_req_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [31:0]      req_pc,
    output logic             req_ready,
    output logic             icache_req,
    output logic [31:0]      icache_addr,
    input  logic             icache_addr_ok,
    input  logic             icache_data_ok,
    input  logic [31:0]      icache_rdata1,
    input  logic [31:0]      icache_rdata2,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata1,
    output logic [31:0]      resp_rdata2,
    output logic [CNT_W-1:0] inflight,
    output logic             protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_REQ_KILL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W-1:0] inflight_nxt;
    logic [CNT_W-1:0] cancel_nxt;
    logic             addr_hs;
    logic             dat;
    logic             dat_cnt;
    logic             req_fire;
    logic             kill_hs;
    logic             cancel_dec;

    assign icache_req = (state != S_IDLE) && (inflight < MAX_CNT);
    assign addr_hs    = icache_req && icache_addr_ok;
    assign dat        = icache_data_ok;
    // A data_ok with nothing outstanding is a protocol violation and must not move the counters.
    assign dat_cnt    = dat && (inflight != '0);
    assign req_ready  = resetn && !flush && ((state == S_IDLE) || ((state == S_REQ) && addr_hs));
    assign req_fire   = req_valid && req_ready;
    assign kill_hs    = (state == S_REQ_KILL) && addr_hs;
    assign cancel_dec = dat && (cancel_cnt != '0);

    assign resp_valid  = dat_cnt && (cancel_cnt == '0) && !flush;
    assign resp_rdata1 = icache_rdata1;
    assign resp_rdata2 = icache_rdata2;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_fire)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                if (addr_hs)
                    state_nxt = req_fire ? S_REQ : S_IDLE;
                else if (flush)
                    state_nxt = S_REQ_KILL;
            end
            S_REQ_KILL: begin
                if (addr_hs)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // On flush every request accepted so far, including this cycle's, belongs to the dead stream.
    always_comb begin
        inflight_nxt = inflight + CNT_W'(addr_hs) - CNT_W'(dat_cnt);
        if (flush)
            cancel_nxt = inflight_nxt;
        else
            cancel_nxt = cancel_cnt + CNT_W'(kill_hs) - CNT_W'(cancel_dec);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            inflight     <= '0;
            cancel_cnt   <= '0;
            icache_addr  <= '0;
            protocol_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            inflight   <= inflight_nxt;
            cancel_cnt <= cancel_nxt;
            if (req_fire)
                icache_addr <= req_pc;
            if (dat && (inflight == '0))
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl: scoreboarded responses plus per-step immediate assertions.
module tb_fetch_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata1;
    logic [31:0] icache_rdata2;
    logic        resp_valid;
    logic [31:0] resp_rdata1;
    logic [31:0] resp_rdata2;
    logic [1:0]  inflight;
    logic        protocol_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    fetch_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata1  (icache_rdata1),
        .icache_rdata2  (icache_rdata2),
        .resp_valid     (resp_valid),
        .resp_rdata1    (resp_rdata1),
        .resp_rdata2    (resp_rdata2),
        .inflight       (inflight),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd1(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rd2(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({rd1(pc), rd2(pc)});
    endtask

    task automatic set_in(input logic rv, input logic [31:0] pc, input logic aok,
                          input logic dok, input logic [31:0] dpc, input logic fl);
        req_valid      = rv;
        req_pc         = pc;
        icache_addr_ok = aok;
        icache_data_ok = dok;
        icache_rdata1  = rd1(dpc);
        icache_rdata2  = rd2(dpc);
        flush          = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL resp_unexpected: observed resp_valid=1 expected no live response");
            end else begin
                exp_e = exp_q.pop_front();
                chk("resp_rdata1", resp_rdata1, exp_e[63:32]);
                chk("resp_rdata2", resp_rdata2, exp_e[31:0]);
            end
        end
    end

    // Streaming run: addr_ok every cycle, ICache answers two cycles after each address handshake.
    task automatic run_stream(input int n_offer, input logic [31:0] pc_start);
        logic [31:0] q_pc[$];
        logic [31:0] p_pc[2];
        logic        p_v[2];
        logic [31:0] pc_next;
        logic [31:0] hs_pc;
        logic        hs;
        logic        done;
        int          offered;
        pc_next = pc_start;
        offered = 0;
        done    = 1'b0;
        p_v[0]  = 1'b0;
        p_v[1]  = 1'b0;
        p_pc[0] = '0;
        p_pc[1] = '0;
        for (int it = 0; it < 60; it++) begin
            if (p_v[1])
                push_exp(p_pc[1]);
            set_in(offered < n_offer, pc_next, 1'b1, p_v[1], p_pc[1], 1'b0);
            if (it == 0)
                chk("stream_first_req_low", icache_req, 0);
            if (it == 1)
                chk("stream_req_cycle1", icache_req, 1);
            if (p_v[1])
                chk("stream_resp_valid", resp_valid, 1);
            chk("stream_inflight_le_max", 32'(inflight <= 2'd2), 1);
            hs    = icache_req && icache_addr_ok;
            hs_pc = '0;
            if (hs) begin
                chk("stream_issue_pending", 32'(q_pc.size() > 0), 1);
                if (q_pc.size() > 0) begin
                    hs_pc = q_pc.pop_front();
                    chk("stream_icache_addr", icache_addr, hs_pc);
                end
            end
            if (req_valid && req_ready) begin
                q_pc.push_back(pc_next);
                pc_next = pc_next + 32'd8;
                offered++;
            end
            p_v[1]  = p_v[0];
            p_pc[1] = p_pc[0];
            p_v[0]  = hs;
            p_pc[0] = hs_pc;
            tick();
            if (offered == n_offer && q_pc.size() == 0 && !p_v[0] && !p_v[1]) begin
                done = 1'b1;
                break;
            end
        end
        chk("stream_done_in_budget", 32'(done), 1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("stream_all_resp_seen", exp_q.size(), 0);
        chk("stream_inflight_drained", inflight, 0);
    endtask

    initial begin
        // Reset: req_valid high must not leak through req_ready.
        resetn = 1'b0;
        set_in(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_icache_req", icache_req, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_icache_addr", icache_addr, 0);
        chk("rst_protocol_err", protocol_err, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 1: streaming from the boot vector.
        run_stream(8, 32'hBFC0_0000);
        tick();

        // 2: outstanding limit and reassertion after the first data_ok.
        set_in(1'b1, 32'h8000_0000, 1'b1, 1'b0, '0, 1'b0);
        chk("max_ready_idle", req_ready, 1);
        tick();
        set_in(1'b1, 32'h8000_0008, 1'b1, 1'b0, '0, 1'b0);
        chk("max_req_a", icache_req, 1);
        chk("max_addr_a", icache_addr, 32'h8000_0000);
        tick();
        set_in(1'b1, 32'h8000_0010, 1'b1, 1'b0, '0, 1'b0);
        chk("max_inflight_1", inflight, 1);
        tick();
        set_in(1'b1, 32'h8000_0018, 1'b1, 1'b0, '0, 1'b0);
        chk("max_inflight_2", inflight, 2);
        chk("max_req_blocked", icache_req, 0);
        chk("max_ready_blocked", req_ready, 0);
        tick();
        set_in(1'b1, 32'h8000_0018, 1'b1, 1'b0, '0, 1'b0);
        chk("max_req_still_blocked", icache_req, 0);
        tick();
        push_exp(32'h8000_0000);
        set_in(1'b1, 32'h8000_0018, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
        chk("max_resp_a", resp_valid, 1);
        chk("max_req_low_on_dat", icache_req, 0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("max_req_reassert", icache_req, 1);
        chk("max_addr_c", icache_addr, 32'h8000_0010);
        tick();
        push_exp(32'h8000_0008);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0008, 1'b0);
        chk("max_inflight_full_again", inflight, 2);
        chk("max_idle_no_req", icache_req, 0);
        tick();
        push_exp(32'h8000_0010);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0010, 1'b0);
        chk("max_inflight_drain", inflight, 1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("max_inflight_zero", inflight, 0);
        tick();

        // 3: flush with two requests outstanding; both answers dropped, new stream live.
        set_in(1'b1, 32'h8000_0100, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0108, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("fl2_inflight_1", inflight, 1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        chk("fl2_ready_blocked", req_ready, 0);
        chk("fl2_inflight_2", inflight, 2);
        tick();
        set_in(1'b1, 32'h8000_0180, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
        chk("fl2_drop_1", resp_valid, 0);
        chk("fl2_ready_new", req_ready, 1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b1, 32'h8000_0108, 1'b0);
        chk("fl2_drop_2", resp_valid, 0);
        chk("fl2_req_new", icache_req, 1);
        chk("fl2_addr_new", icache_addr, 32'h8000_0180);
        tick();
        push_exp(32'h8000_0180);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0180, 1'b0);
        chk("fl2_live_resp", resp_valid, 1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("fl2_inflight_zero", inflight, 0);
        tick();

        // 4: flush while the held request is not yet accepted.
        set_in(1'b1, 32'h8000_0200, 1'b0, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0208, 1'b0, 1'b0, '0, 1'b1);
        chk("kill_ready_flush", req_ready, 0);
        chk("kill_req_held", icache_req, 1);
        tick();
        set_in(1'b1, 32'h8000_0208, 1'b0, 1'b0, '0, 1'b0);
        chk("kill_ready_blocked", req_ready, 0);
        chk("kill_addr_kept", icache_addr, 32'h8000_0200);
        tick();
        set_in(1'b1, 32'h8000_0208, 1'b0, 1'b0, '0, 1'b0);
        chk("kill_req_still_held", icache_req, 1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("kill_ready_on_hs", req_ready, 0);
        chk("kill_inflight_0", inflight, 0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0200, 1'b0);
        chk("kill_inflight_1", inflight, 1);
        chk("kill_idle", icache_req, 0);
        chk("kill_drop", resp_valid, 0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("kill_inflight_zero", inflight, 0);
        tick();

        // 5: flush coinciding with an address handshake and a data_ok.
        set_in(1'b1, 32'h8000_0300, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0308, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0310, 1'b1, 1'b1, 32'h8000_0300, 1'b1);
        chk("sim_ready_blocked", req_ready, 0);
        chk("sim_resp_dropped", resp_valid, 0);
        chk("sim_req_hs", icache_req, 1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0308, 1'b0);
        chk("sim_inflight_1", inflight, 1);
        chk("sim_idle", icache_req, 0);
        chk("sim_cancelled_drop", resp_valid, 0);
        tick();
        set_in(1'b1, 32'h8000_0340, 1'b1, 1'b0, '0, 1'b0);
        chk("sim_inflight_zero", inflight, 0);
        chk("sim_ready_new", req_ready, 1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        chk("sim_addr_new", icache_addr, 32'h8000_0340);
        tick();
        push_exp(32'h8000_0340);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h8000_0340, 1'b0);
        chk("sim_live_resp", resp_valid, 1);
        tick();

        // 6: stray data_ok, sticky error, then asynchronous reset mid-burst.
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        chk("perr_resp_low", resp_valid, 0);
        chk("perr_not_yet", protocol_err, 0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("perr_set", protocol_err, 1);
        chk("perr_inflight_0", inflight, 0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("perr_sticky", protocol_err, 1);
        tick();
        set_in(1'b1, 32'h8000_0400, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0408, 1'b1, 1'b0, '0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000_0410, 1'b1, 1'b0, '0, 1'b0);
        chk("arst_pre_inflight", inflight, 1);
        chk("arst_pre_req", icache_req, 1);
        #1;
        resetn         = 1'b0;
        icache_data_ok = 1'b1;
        #1;
        chk("arst_icache_req", icache_req, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_inflight", inflight, 0);
        chk("arst_icache_addr", icache_addr, 0);
        chk("arst_protocol_err", protocol_err, 0);
        chk("arst_resp_valid", resp_valid, 0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        resetn = 1'b1;
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
